// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-entry valid/ready output buffer.
// Optional 2-of-3 majority bit decision: define UART_RX_MAJORITY_EN.
module uart_rx_os #(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W  = $clog2(DATA_BITS + 3);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMP_PT = OVERSAMPLE / 2 + 1;
`else
    localparam int unsigned SAMP_PT = OVERSAMPLE / 2;
`endif

    if (DIV < 1) begin : g_chk_div
        $error("uart_rx_os: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_db
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if ((PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_fmt
        $error("uart_rx_os: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_d;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_tick;
    logic w_samp;
    logic w_bit;
    logic w_fall;

    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_samp = w_tick && (r_os_cnt == OS_W'(SAMP_PT));
    assign w_fall = r_rxs_d && !r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    // Capture the two samples preceding the deciding one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_maj <= 2'b11;
        end else if (w_tick && ((r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) ||
                                (r_os_cnt == OS_W'(OVERSAMPLE / 2)))) begin
            r_maj <= {r_maj[0], r_sync2};
        end
    end

    assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_sync2) | (r_maj[1] & r_sync2);
`else
    assign w_bit = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_d    <= 1'b1;
            r_div_cnt  <= '0;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
            overrun <= 1'b0;

            // Tick generator, re-phased to the detected start edge.
            if ((r_state == S_IDLE) && w_fall) begin
                r_div_cnt <= '0;
                r_os_cnt  <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= (r_os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + OS_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        busy      <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_samp) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_par     <= 1'b0;
                            r_perr    <= 1'b0;
                            r_ferr    <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_samp) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_bit;
                        if (r_bit_cnt == BC_W'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_samp) begin
                        r_perr  <= (PARITY == 1) ? ~(r_par ^ w_bit) : (r_par ^ w_bit);
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_samp) begin
                        if (r_bit_cnt == BC_W'(STOP_BITS - 1)) begin
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                            r_bit_cnt <= '0;
                            // A free buffer (or one being drained) takes the word.
                            if (!valid || ready) begin
                                data       <= r_shift;
                                parity_err <= r_perr;
                                frame_err  <= r_ferr | ~w_bit;
                                valid      <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            r_ferr    <= r_ferr | ~w_bit;
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 receiver and an 8E2 receiver at 16 clk/bit.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ready;
    logic       line;
    int         sel;
    logic       rxd_a, rxd_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    assign rxd_a = (sel == 0) ? line : 1'b1;
    assign rxd_b = (sel == 1) ? line : 1'b1;

    uart_rx_os #(
        .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .valid(valid_a),
        .ready(ready), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_os #(
        .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .valid(valid_b),
        .ready(ready), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ovr_cnt_a = 0;
    int vrise_a   = 0;
    logic valid_a_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Count overrun pulses and new-word arrivals on receiver A.
    always @(negedge clk) begin
        if (ovr_a === 1'b1) ovr_cnt_a++;
        if (valid_a === 1'b1 && valid_a_q !== 1'b1) vrise_a++;
        valid_a_q = valid_a;
    end

    task automatic send_bit(input logic v);
        line = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input bit has_par,
                              input logic pbit, input bit two_stop, input logic s2);
        sel = s;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(1'b1);
        if (two_stop) send_bit(s2);
        line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vr0;
        rst   = 1'b1;
        ready = 1'b0;
        line  = 1'b1;
        sel   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_busy_a",  32'(busy_a), 0);
        check("rst_data_a",  32'(data_a), 0);
        check("rst_flags_a", 32'({perr_a, ferr_a, ovr_a}), 0);
        check("rst_valid_b", 32'(valid_b), 0);

        // Basic 8N1 word held until accepted
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_valid", 32'(valid_a), 1);
        check("a5_data",  32'(data_a), 32'hA5);
        check("a5_flags", 32'({perr_a, ferr_a}), 0);
        repeat (20) @(negedge clk);
        check("a5_hold_valid", 32'(valid_a), 1);
        check("a5_hold_data",  32'(data_a), 32'hA5);
        accept();
        check("a5_accept", 32'(valid_a), 0);

        // Short start glitch is rejected
        sel  = 0;
        line = 1'b0;
        repeat (5) @(negedge clk);
        line = 1'b1;
        check("glitch_busy_hi", 32'(busy_a), 1);
        repeat (10) @(negedge clk);
        check("glitch_busy_lo", 32'(busy_a), 0);
        check("glitch_novalid", 32'(valid_a), 0);
        repeat (8) @(negedge clk);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("3c_valid", 32'(valid_a), 1);
        check("3c_data",  32'(data_a), 32'h3C);
        accept();

        // Overrun: second word dropped while the first is held
        vr0 = vrise_a;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_data",  32'(data_a), 32'h11);
        check("ovr_valid", 32'(valid_a), 1);
        check("ovr_pulses", 32'(ovr_cnt_a), 1);
        accept();
        check("ovr_accept", 32'(valid_a), 0);
        repeat (40) @(negedge clk);
        check("ovr_no_more_valid", 32'(valid_a), 0);
        check("ovr_words", 32'(vrise_a - vr0), 1);

        // Reset mid-frame with a word already held
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        check("5a_data", 32'(data_a), 32'h5A);
        sel = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        line = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_data",  32'(data_a), 0);
        check("mid_rst_busy",  32'(busy_a), 0);
        check("mid_rst_flags", 32'({perr_a, ferr_a, ovr_a}), 0);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("mid_rst_noout", 32'(valid_a), 0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        check("81_valid", 32'(valid_a), 1);
        check("81_data",  32'(data_a), 32'h81);
        accept();

        // Even parity, two stop bits
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        check("p07_bad_data", 32'(data_b), 32'h07);
        check("p07_bad_perr", 32'(perr_b), 1);
        check("p07_bad_ferr", 32'(ferr_b), 0);
        accept();
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        check("p07_ok_valid", 32'(valid_b), 1);
        check("p07_ok_perr",  32'(perr_b), 0);
        accept();
        send_frame(1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        check("s55_data", 32'(data_b), 32'h55);
        check("s55_ferr", 32'(ferr_b), 1);
        check("s55_perr", 32'(perr_b), 0);
        accept();
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        check("s01_data",  32'(data_b), 32'h01);
        check("s01_flags", 32'({perr_b, ferr_b}), 0);
        accept();
        check("b_accept", 32'(valid_b), 0);

`ifdef UART_RX_MAJORITY_EN
        // One-clock low glitch inside the centre window of a '1' bit
        sel = 0;
        send_bit(1'b0);
        line = 1'b1;
        repeat (8) @(negedge clk);
        line = 1'b0;
        @(negedge clk);
        line = 1'b1;
        repeat (7) @(negedge clk);
        for (int i = 1; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        check("maj_valid", 32'(valid_a), 1);
        check("maj_data",  32'(data_a), 32'h01);
        accept();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
